// File: rtl/spi_master_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_xfer_ctrl
//
// Master-side SPI transfer sequencer. Buffers one pending TX word, pulls ss
// low to start the baud rate generator, shifts mosi/miso on the generator's
// sample strobe, counts bits, then releases ss for a guard gap and raises the
// sticky transfer-complete flag.
//
// Ports
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   spe, mstr, spiswai     enable / master select / stop-in-wait
//   spi_mode[1:0]          00 run, 01 wait, 1x stop
//   cpol, cpha, lsbfe      clock polarity/phase, bit order (1 = LSB first)
//   send_data, tx_data     one-cycle load strobe and the word to send
//   spif_clr               one-cycle clear strobe for spif
//   miso                   serial data in
//   flag_low, flag_high    baud generator phase-end strobes
//   ss                     slave select, active low (registered)
//   mosi                   serial data out (combinational from registers)
//   rx_data                last completed received word
//   spif                   transfer complete, sticky
//   tx_ovr                 one-cycle pulse: load while buffer already full
//   busy                   sequencer not idle (registered)
// -----------------------------------------------------------------------------
module spi_master_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int SS_GAP = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              spe,
    input  logic              mstr,
    input  logic              spiswai,
    input  logic [1:0]        spi_mode,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic              send_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              spif_clr,
    input  logic              miso,
    input  logic              flag_low,
    input  logic              flag_high,
    output logic              ss,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              spif,
    output logic              tx_ovr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int GAP_W = $clog2(SS_GAP + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               ss_q, ss_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               spif_q, spif_d;
    logic               tx_ovr_q, tx_ovr_d;
    logic [DATA_W-1:0]  tx_buf_q, tx_buf_d;
    logic               pending_q, pending_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               active;
    logic               strobe;
    logic               spif_set;
    logic [DATA_W-1:0]  shifted;

    assign active = spe & mstr & ~spiswai & ~spi_mode[1];
    // Modes 0 and 3 sample on the end of the low phase, modes 1 and 2 on the
    // end of the high phase.
    assign strobe = (cpol ^ cpha) ? flag_high : flag_low;

    // Outgoing bit sits at the end the word leaves from; incoming bit enters
    // at the opposite end so the first received bit ends up in place.
    assign shifted = lsbfe ? {miso, shift_q[DATA_W-1:1]}
                           : {shift_q[DATA_W-2:0], miso};

    always_comb begin
        state_d   = state_q;
        rx_d      = rx_q;
        tx_ovr_d  = 1'b0;
        tx_buf_d  = tx_buf_q;
        pending_d = pending_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        spif_set  = 1'b0;

        // TX buffer. LOAD consumes the buffer, so a load in that same cycle is
        // a fresh word rather than an overrun.
        if (send_data) begin
            tx_buf_d  = tx_data;
            pending_d = 1'b1;
            if (pending_q && (state_q != LOAD)) begin
                tx_ovr_d = 1'b1;
            end
        end else if (state_q == LOAD) begin
            pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (active && pending_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bit_cnt_d = '0;
                if (active) begin
                    shift_d = tx_buf_q;
                    state_d = XFER;
                end else begin
                    shift_d = '0;
                    state_d = IDLE;
                end
            end
            XFER: begin
                if (!active) begin
                    // Abort: partial word is dropped, rx_data/spif untouched.
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else if (strobe) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_d      = shifted;
                        spif_set  = 1'b1;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(SS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion beats a simultaneous clear so no transfer is ever lost.
        if (spif_set) begin
            spif_d = 1'b1;
        end else if (spif_clr) begin
            spif_d = 1'b0;
        end else begin
            spif_d = spif_q;
        end

        // Registered from the next state so ss/busy line up with state_q.
        ss_d   = ~((state_d == LOAD) || (state_d == XFER));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            rx_q      <= '0;
            spif_q    <= 1'b0;
            tx_ovr_q  <= 1'b0;
            tx_buf_q  <= '0;
            pending_q <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            rx_q      <= rx_d;
            spif_q    <= spif_d;
            tx_ovr_q  <= tx_ovr_d;
            tx_buf_q  <= tx_buf_d;
            pending_q <= pending_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign ss      = ss_q;
    assign busy    = busy_q;
    assign rx_data = rx_q;
    assign spif    = spif_q;
    assign tx_ovr  = tx_ovr_q;
    assign mosi    = ss_q ? 1'b0 : (lsbfe ? shift_q[0] : shift_q[DATA_W-1]);

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_xfer_ctrl
//
// Scoreboard bench: stimulus pushes expected mosi bits, received words, overrun
// pulses and point checks into queues; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_spi_master_xfer_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       spe, mstr, spiswai;
    logic [1:0] spi_mode;
    logic       cpol, cpha, lsbfe;
    logic       send_data;
    logic [7:0] tx_data;
    logic       spif_clr;
    logic       miso;
    logic       flag_low, flag_high;
    logic       ss, mosi, spif, tx_ovr, busy;
    logic [7:0] rx_data;

    spi_master_xfer_ctrl #(.DATA_W(8), .SS_GAP(2)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .spe       (spe),
        .mstr      (mstr),
        .spiswai   (spiswai),
        .spi_mode  (spi_mode),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsbfe     (lsbfe),
        .send_data (send_data),
        .tx_data   (tx_data),
        .spif_clr  (spif_clr),
        .miso      (miso),
        .flag_low  (flag_low),
        .flag_high (flag_high),
        .ss        (ss),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .spif      (spif),
        .tx_ovr    (tx_ovr),
        .busy      (busy)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    chk_t       req_q[$];
    logic       exp_mosi_q[$];
    logic [7:0] exp_rx_q[$];
    int         exp_ovr_q[$];

    int   checks = 0;
    int   errors = 0;
    chk_t r;
    logic e_bit;
    logic [7:0] e_word;
    logic sel;
    logic spif_prev = 1'b0;
    logic ovr_prev  = 1'b0;
    int   ovr_tag;

    // Monitor / scoreboard
    always @(negedge PCLK) begin
        while (req_q.size() > 0) begin
            r = req_q.pop_front();
            checks++;
            if (r.act !== r.exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", r.name, r.act, r.exp);
            end
        end
        if (PRESETn) begin
            sel = (cpol ^ cpha) ? flag_high : flag_low;
            if (sel && !ss) begin
                checks++;
                if (exp_mosi_q.size() == 0) begin
                    errors++;
                    $display("FAIL mosi_unexpected: got %0b expected no strobe", mosi);
                end else begin
                    e_bit = exp_mosi_q.pop_front();
                    if (mosi !== e_bit) begin
                        errors++;
                        $display("FAIL mosi_bit: got %0b expected %0b", mosi, e_bit);
                    end
                end
            end
            if (spif && !spif_prev) begin
                checks++;
                if (exp_rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got 0x%02h expected no completion", rx_data);
                end else begin
                    e_word = exp_rx_q.pop_front();
                    if (rx_data !== e_word) begin
                        errors++;
                        $display("FAIL rx_data: got 0x%02h expected 0x%02h", rx_data, e_word);
                    end else begin
                        $display("xfer complete rx_data=0x%02h", rx_data);
                    end
                end
            end
            if (tx_ovr) begin
                checks++;
                if (ovr_prev) begin
                    errors++;
                    $display("FAIL tx_ovr_width: got high 2 cycles expected 1-cycle pulse");
                end else if (exp_ovr_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_ovr_unexpected: got 1 expected 0");
                end else begin
                    ovr_tag = exp_ovr_q.pop_front();
                    $display("tx_ovr pulse %0d seen", ovr_tag);
                end
            end
            spif_prev = spif;
            ovr_prev  = tx_ovr;
        end else begin
            spif_prev = 1'b0;
            ovr_prev  = 1'b0;
        end
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        req_q.push_back(c);
    endtask

    task automatic send(input logic [7:0] w);
        send_data = 1'b1;
        tx_data   = w;
        tick();
        send_data = 1'b0;
    endtask

    // Waits for ss low (LOAD), then one more cycle so the sequencer is in XFER.
    task automatic wait_xfer(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ss) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("ss_start_timeout", 32'd0, 32'd1);
        else     tick();
    endtask

    // Issues nbits sample strobes; idle cycles between them pulse the other flag
    // so the strobe selection is exercised.
    task automatic run_bits(input logic [7:0] tx, input logic [7:0] rx,
                            input int nbits, input bit clr_last);
        int  idx;
        bit  use_high;
        use_high = cpol ^ cpha;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfe ? i : 7 - i;
            exp_mosi_q.push_back(tx[idx]);
            miso = rx[idx];
            if (use_high) flag_high = 1'b1;
            else          flag_low  = 1'b1;
            spif_clr = clr_last && (i == nbits - 1);
            tick();
            flag_high = 1'b0;
            flag_low  = 1'b0;
            spif_clr  = 1'b0;
            if (i != nbits - 1) begin
                if (use_high) flag_low  = 1'b1;
                else          flag_high = 1'b1;
                tick();
                flag_high = 1'b0;
                flag_low  = 1'b0;
            end
        end
    endtask

    task automatic clear_spif;
        spif_clr = 1'b1;
        tick();
        spif_clr = 1'b0;
        chk("spif_cleared", 32'(spif), 32'd0);
    endtask

    initial begin
        bit ok;
        PRESETn   = 1'b0;
        spe       = 1'b1;
        mstr      = 1'b1;
        spiswai   = 1'b0;
        spi_mode  = 2'b00;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsbfe     = 1'b0;
        send_data = 1'b0;
        tx_data   = 8'h00;
        spif_clr  = 1'b0;
        miso      = 1'b0;
        flag_low  = 1'b0;
        flag_high = 1'b0;

        tick();
        tick();
        chk("rst_ss",     32'(ss),      32'd1);
        chk("rst_mosi",   32'(mosi),    32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_spif",   32'(spif),    32'd0);
        chk("rst_rxdata", 32'(rx_data), 32'd0);
        PRESETn = 1'b1;
        tick();

        // 1: asynchronous reset in the middle of a transfer
        send(8'hF0);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'hF0, 8'hFF, 2, 1'b0);
            chk("mid_xfer_ss_low", 32'(ss), 32'd0);
            #2 PRESETn = 1'b0;
            #1;
            chk("arst_ss",     32'(ss),      32'd1);
            chk("arst_mosi",   32'(mosi),    32'd0);
            chk("arst_busy",   32'(busy),    32'd0);
            chk("arst_spif",   32'(spif),    32'd0);
            chk("arst_rxdata", 32'(rx_data), 32'd0);
            chk("arst_txovr",  32'(tx_ovr),  32'd0);
            tick();
            PRESETn = 1'b1;
        end
        tick();

        // 2: mode 0, MSB first, 0xA5 out / 0x3C in
        exp_rx_q.push_back(8'h3C);
        send(8'hA5);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'hA5, 8'h3C, 8, 1'b0);
            chk("t2_gap_ss_c1",   32'(ss),   32'd1);
            chk("t2_gap_busy_c1", 32'(busy), 32'd1);
            chk("t2_spif",        32'(spif), 32'd1);
            tick();
            chk("t2_gap_ss_c2",   32'(ss),   32'd1);
            chk("t2_gap_busy_c2", 32'(busy), 32'd1);
            tick();
            chk("t2_idle_busy",   32'(busy), 32'd0);
            clear_spif();
        end

        // 3: cpol=1 cpha=0 (flag_high), LSB first, 0x01 out / 0x80 in
        cpol  = 1'b1;
        lsbfe = 1'b1;
        exp_rx_q.push_back(8'h80);
        send(8'h01);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'h01, 8'h80, 8, 1'b0);
            chk("t3_rxdata", 32'(rx_data), 32'h80);
            tick();
            tick();
            clear_spif();
        end

        // 4: abort after three strobes
        cpol  = 1'b0;
        lsbfe = 1'b0;
        send(8'hC3);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'hC3, 8'h00, 3, 1'b0);
            spe = 1'b0;
            tick();
            chk("t4_abort_ss",   32'(ss),      32'd1);
            chk("t4_abort_busy", 32'(busy),    32'd0);
            chk("t4_abort_spif", 32'(spif),    32'd0);
            chk("t4_abort_rx",   32'(rx_data), 32'h80);
            spe = 1'b1;
            tick();
            tick();
            tick();
            chk("t4_no_restart", 32'(ss), 32'd1);
        end

        // 5: overrun while held in stop mode; the second word is sent
        spi_mode = 2'b10;
        exp_ovr_q.push_back(5);
        send(8'h11);
        send(8'h22);
        tick();
        tick();
        chk("t5_stop_ss",   32'(ss),   32'd1);
        chk("t5_stop_busy", 32'(busy), 32'd0);
        cpha     = 1'b1;
        spi_mode = 2'b00;
        exp_rx_q.push_back(8'h5A);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'h22, 8'h5A, 8, 1'b0);
            tick();
            tick();
            clear_spif();
        end

        // 6: clear coincident with completion loses; later clear wins
        cpol  = 1'b1;
        lsbfe = 1'b1;
        exp_rx_q.push_back(8'h96);
        send(8'hC3);
        wait_xfer(ok);
        if (ok) begin
            run_bits(8'hC3, 8'h96, 8, 1'b1);
            chk("t6_set_wins", 32'(spif), 32'd1);
            tick();
            tick();
            clear_spif();
        end

        chk("left_mosi", 32'(exp_mosi_q.size()), 32'd0);
        chk("left_rx",   32'(exp_rx_q.size()),   32'd0);
        chk("left_ovr",  32'(exp_ovr_q.size()),  32'd0);
        @(negedge PCLK);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
